// File: rtl/squiggle_normalizer_pkg.sv
// Shared widths, state encoding and the per-sample normalisation arithmetic for
// the squiggle normaliser.
package dtw_norm_pkg;

  localparam int unsigned WIDTH      = 16;
  localparam int unsigned SQG_SIZE   = 256;
  localparam int unsigned LOG2_SQG   = 8;
  localparam int unsigned RECIP_FRAC = 24;
  localparam int unsigned OUT_FRAC   = 8;

  localparam int unsigned SUM_W   = WIDTH + LOG2_SQG;
  localparam int unsigned RECIP_W = RECIP_FRAC + 1;
  localparam int unsigned PROD_W  = WIDTH + 1 + RECIP_W;
  localparam int unsigned CNT_W   = LOG2_SQG + 1;

  localparam logic [WIDTH-1:0] OFFSET = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [2:0] {LOAD, MEAN, MAD, DIV, STREAM} state_t;

  // (x-mean)*recip rescaled to OUT_FRAC bits, saturated, then offset-binary
  function automatic logic [WIDTH-1:0] norm_sample(input logic signed [WIDTH:0] diff,
                                                   input logic [RECIP_W-1:0] recip);
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;
    logic signed [PROD_W-1:0] sat_hi;
    logic signed [PROD_W-1:0] sat_lo;
    logic signed [PROD_W-1:0] sat;
    sat_hi  = PROD_W'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
    sat_lo  = -sat_hi - PROD_W'(1);
    prod    = PROD_W'(diff) * PROD_W'($signed({1'b0, recip}));
    shifted = prod >>> (RECIP_FRAC - OUT_FRAC);
    if (shifted > sat_hi)      sat = sat_hi;
    else if (shifted < sat_lo) sat = sat_lo;
    else                       sat = shifted;
    return WIDTH'(sat) ^ OFFSET;
  endfunction

endpackage

// File: rtl/squiggle_normalizer_if.sv
// Raw-sample input stream and normalised-sample output stream of the normaliser.
interface squiggle_normalizer_if
  import dtw_norm_pkg::*;
();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_last);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/squiggle_normalizer_recip_divider.sv
// Iterative restoring divider: quotient = floor(2^RECIP_FRAC / divisor),
// one quotient bit per cycle after a start pulse.
module recip_divider
  import dtw_norm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_divisor,
  output logic               o_done_c,
  output logic [RECIP_W-1:0] o_quot
);
  localparam int unsigned IT_W = $clog2(RECIP_W);

  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_rem;
  logic [RECIP_W-1:0] r_quot;
  logic [IT_W-1:0]    r_iter;
  logic               r_run;

  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;

  // dividend is a single 1 in the MSB, so only the first iteration shifts in a 1
  assign w_trial    = {r_rem, (r_iter == '0)};
  assign w_ge       = w_trial >= {1'b0, r_divisor};
  assign w_rem_next = w_ge ? WIDTH'(w_trial - {1'b0, r_divisor}) : WIDTH'(w_trial);
  assign o_done_c   = r_run && (r_iter == IT_W'(RECIP_W - 1));
  assign o_quot     = r_quot;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_divisor <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_iter    <= '0;
      r_run     <= 1'b0;
    end else if (i_start) begin
      r_divisor <= i_divisor;
      r_rem     <= '0;
      r_quot    <= '0;
      r_iter    <= '0;
      r_run     <= 1'b1;
    end else if (r_run) begin
      r_rem  <= w_rem_next;
      r_quot <= {r_quot[RECIP_W-2:0], w_ge};
      r_iter <= r_iter + IT_W'(1);
      if (o_done_c) r_run <= 1'b0;
    end
  end
endmodule

// File: rtl/squiggle_normalizer.sv
// Buffers one read of raw ADC samples, derives mean/MAD and a reciprocal of MAD,
// then streams the samples back normalised to (x-mean)/MAD in offset binary.
module squiggle_normalizer
  import dtw_norm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  squiggle_normalizer_if.slave s,
  output logic              busy,
  output logic              mad_zero,
  output logic [WIDTH-1:0]  mean_o,
  output logic [WIDTH-1:0]  mad_o
);
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [SUM_W-1:0]   r_sum;
  logic [SUM_W-1:0]   r_dsum;
  logic [WIDTH-1:0]   r_mean;
  logic [WIDTH-1:0]   r_mad;
  logic               r_mad_zero;
  logic               r_busy;
  logic               r_in_ready;
  logic               r_s1_v;
  logic               r_s1_last;
  logic               r_out_valid;
  logic               r_out_last;
  logic [WIDTH-1:0]   r_out_data;
  logic [WIDTH-1:0]   r_mem [SQG_SIZE];
  logic [WIDTH-1:0]   r_ram_q;

  logic                  w_accept;
  logic                  w_adv;
  logic                  w_rd_en;
  logic [LOG2_SQG-1:0]   w_addr;
  logic signed [WIDTH:0] w_diff;
  logic [WIDTH-1:0]      w_abs;
  logic [SUM_W-1:0]      w_dsum_next;
  logic [WIDTH-1:0]      w_mad_next;
  logic                  w_mad_end;
  logic                  w_div_start;
  logic                  w_div_done_c;
  logic [RECIP_W-1:0]    w_div_quot;
  logic [RECIP_W-1:0]    w_recip;

  assign w_accept    = s.in_valid && r_in_ready;
  assign w_adv       = !r_out_valid || s.out_ready;
  assign w_addr      = r_cnt[LOG2_SQG-1:0];
  assign w_rd_en     = (r_state == MAD) || ((r_state == STREAM) && w_adv);
  assign w_diff      = $signed({1'b0, r_ram_q}) - $signed({1'b0, r_mean});
  assign w_abs       = w_diff[WIDTH] ? WIDTH'(-w_diff) : WIDTH'(w_diff);
  assign w_dsum_next = r_dsum + SUM_W'(w_abs);
  assign w_mad_next  = WIDTH'(w_dsum_next >> LOG2_SQG);
  assign w_mad_end   = (r_state == MAD) && (r_cnt == CNT_W'(SQG_SIZE));
  assign w_div_start = w_mad_end && (w_mad_next != '0);
  assign w_recip     = r_mad_zero ? '0 : w_div_quot;

  recip_divider u_div (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_div_start),
    .i_divisor (w_mad_next),
    .o_done_c  (w_div_done_c),
    .o_quot    (w_div_quot)
  );

  // sample buffer: written in LOAD, read synchronously in MAD and STREAM
  always_ff @(posedge clk) begin
    if ((r_state == LOAD) && w_accept) r_mem[w_addr] <= s.in_data;
    if (w_rd_en) r_ram_q <= r_mem[w_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LOAD;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_dsum      <= '0;
      r_mean      <= '0;
      r_mad       <= '0;
      r_mad_zero  <= 1'b0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_s1_v      <= 1'b0;
      r_s1_last   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_accept) begin
            r_sum <= r_sum + SUM_W'(s.in_data);
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(SQG_SIZE - 1)) begin
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
              r_cnt      <= '0;
              r_state    <= MEAN;
            end
          end
        end
        MEAN: begin
          r_mean  <= WIDTH'(r_sum >> LOG2_SQG);
          r_dsum  <= '0;
          r_cnt   <= '0;
          r_state <= MAD;
        end
        MAD: begin
          // r_ram_q lags the address by one cycle, so accumulation starts at cnt 1
          if (r_cnt != '0) r_dsum <= w_dsum_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_mad_end) begin
            r_mad      <= w_mad_next;
            r_mad_zero <= (w_mad_next == '0);
            r_cnt      <= '0;
            r_state    <= DIV;
          end
        end
        DIV: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_mad_zero ? (r_cnt == CNT_W'(RECIP_W - 1)) : w_div_done_c) begin
            r_cnt   <= '0;
            r_state <= STREAM;
          end
        end
        STREAM: begin
          if (w_adv) begin
            if (r_cnt != CNT_W'(SQG_SIZE)) begin
              r_cnt     <= r_cnt + CNT_W'(1);
              r_s1_v    <= 1'b1;
              r_s1_last <= (r_cnt == CNT_W'(SQG_SIZE - 1));
            end else begin
              r_s1_v    <= 1'b0;
              r_s1_last <= 1'b0;
            end
            r_out_valid <= r_s1_v;
            r_out_last  <= r_s1_last;
            r_out_data  <= norm_sample(w_diff, w_recip);
          end
          if (r_out_valid && s.out_ready && r_out_last) begin
            r_cnt      <= '0;
            r_sum      <= '0;
            r_dsum     <= '0;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
            r_state    <= LOAD;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign s.in_ready  = r_in_ready;
  assign s.out_valid = r_out_valid;
  assign s.out_data  = r_out_data;
  assign s.out_last  = r_out_last;
  assign busy        = r_busy;
  assign mad_zero    = r_mad_zero;
  assign mean_o      = r_mean;
  assign mad_o       = r_mad;
endmodule

// File: tb/tb_squiggle_normalizer.sv
// Randomised bench for squiggle_normalizer against an arithmetic model of
// mean, MAD, reciprocal and per-sample normalisation.
module tb_squiggle_normalizer;
  import dtw_norm_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic busy, mad_zero;
  logic [WIDTH-1:0] mean_o, mad_o;

  always #5 clk = ~clk;

  squiggle_normalizer_if sif ();

  squiggle_normalizer dut (
    .clk      (clk),
    .rst      (rst),
    .s        (sif.slave),
    .busy     (busy),
    .mad_zero (mad_zero),
    .mean_o   (mean_o),
    .mad_o    (mad_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  longint      cyc = 0;
  longint      hs_cyc = 0;
  int unsigned samp [SQG_SIZE];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // floor division that also rounds toward -inf for negative numerators
  function automatic longint floor_div(input longint a, input longint b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  task automatic send_read(input int n, input bit gaps);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(0, 3) == 0) begin
        sif.in_valid = 1'b0;
      end else begin
        sif.in_valid = 1'b1;
        sif.in_data  = 16'(samp[i]);
      end
      if (sif.in_valid && sif.in_ready) begin
        i++;
        hs_cyc = cyc + 1;
      end
    end
    @(negedge clk);
    sif.in_valid = 1'b0;
    if (i < n) chk("in_timeout", i, n);
  endtask

  task automatic recv_read(input string nm, input bit rand_ready, input bit chk_lat);
    longint sum = 0, dsum = 0, mean, mad, recip, v;
    longint exp_out [SQG_SIZE];
    int got = 0, guard = 0, stall_bad = 0, ready_bad = 0, busy_bad = 0;
    bit first = 1'b1, done = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;

    for (int k = 0; k < SQG_SIZE; k++) sum += samp[k];
    mean = sum / SQG_SIZE;
    for (int k = 0; k < SQG_SIZE; k++)
      dsum += (samp[k] >= mean) ? (samp[k] - mean) : (mean - samp[k]);
    mad   = dsum / SQG_SIZE;
    recip = (mad == 0) ? 0 : ((64'd1 << RECIP_FRAC) / mad);
    for (int k = 0; k < SQG_SIZE; k++) begin
      v = floor_div((longint'(samp[k]) - mean) * recip, 64'd1 << (RECIP_FRAC - OUT_FRAC));
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      exp_out[k] = v + 32768;
    end

    while (!done && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (prev_stall && (!sif.out_valid || sif.out_data !== prev_data || sif.out_last !== prev_last))
        stall_bad++;
      if (sif.in_ready) ready_bad++;
      if (!busy) busy_bad++;
      sif.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sif.out_valid && first) begin
        first = 1'b0;
        if (chk_lat) chk({nm, "_latency"}, cyc - hs_cyc, 285);
        chk({nm, "_mean"}, mean_o, mean);
        chk({nm, "_mad"}, mad_o, mad);
        chk({nm, "_mad_zero"}, mad_zero, (mad == 0));
      end
      if (sif.out_valid && sif.out_ready) begin
        if (got < SQG_SIZE) chk($sformatf("%s_data[%0d]", nm, got), sif.out_data, exp_out[got]);
        chk($sformatf("%s_last[%0d]", nm, got), sif.out_last, (got == SQG_SIZE - 1));
        got++;
        if (sif.out_last || got > SQG_SIZE) done = 1'b1;
      end
      prev_stall = sif.out_valid && !sif.out_ready;
      prev_data  = sif.out_data;
      prev_last  = sif.out_last;
    end
    chk({nm, "_count"}, got, SQG_SIZE);
    chk({nm, "_stall_stable"}, stall_bad, 0);
    chk({nm, "_in_ready_low"}, ready_bad, 0);
    chk({nm, "_busy_high"}, busy_bad, 0);
    @(negedge clk);
    chk({nm, "_in_ready_back"}, sif.in_ready, 1);
    chk({nm, "_out_valid_off"}, sif.out_valid, 0);
    chk({nm, "_busy_off"}, busy, 0);
    sif.out_ready = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    sif.in_valid  = 1'b0;
    sif.in_data   = '0;
    sif.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", sif.in_ready, 1);
    chk("rst_out_valid", sif.out_valid, 0);
    chk("rst_out_data", sif.out_data, 0);
    chk("rst_out_last", sif.out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mad_zero", mad_zero, 0);
    chk("rst_mean", mean_o, 0);
    chk("rst_mad", mad_o, 0);
    rst = 1'b0;

    for (int k = 0; k < SQG_SIZE; k++) samp[k] = 1000;
    send_read(SQG_SIZE, 1'b0);
    recv_read("const", 1'b0, 1'b1);

    for (int k = 0; k < SQG_SIZE; k++) samp[k] = (k % 2 == 0) ? 900 : 1100;
    send_read(SQG_SIZE, 1'b0);
    recv_read("alt", 1'b0, 1'b1);

    for (int k = 0; k < SQG_SIZE; k++) samp[k] = (k == SQG_SIZE - 1) ? 65535 : 0;
    send_read(SQG_SIZE, 1'b0);
    recv_read("spike", 1'b0, 1'b1);

    for (int k = 0; k < SQG_SIZE; k++) samp[k] = (k % 2 == 0) ? 900 : 1100;
    send_read(SQG_SIZE, 1'b1);
    recv_read("alt_stall", 1'b1, 1'b0);

    for (int k = 0; k < SQG_SIZE; k++) samp[k] = 1000;
    send_read(100, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", sif.in_ready, 1);
    chk("midrst_busy", busy, 0);
    send_read(SQG_SIZE, 1'b0);
    recv_read("after_rst", 1'b0, 1'b1);

    for (int k = 0; k < SQG_SIZE; k++) samp[k] = $urandom_range(0, 65535);
    send_read(SQG_SIZE, 1'b1);
    recv_read("rand_wide", 1'b1, 1'b0);

    for (int k = 0; k < SQG_SIZE; k++) samp[k] = 30000 + $urandom_range(0, 200);
    send_read(SQG_SIZE, 1'b0);
    recv_read("rand_narrow", 1'b1, 1'b1);

    for (int k = 0; k < SQG_SIZE; k++) samp[k] = 5000;
    send_read(SQG_SIZE, 1'b0);
    recv_read("const2", 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/squiggle_normalizer.md
Name: squiggle_normalizer

Overview:
- Upstream stage of dtw_core_datapath: accepts one read of SQG_SIZE raw unsigned ADC samples, buffers them, and computes mean and mean absolute deviation (MAD).
- Streams the samples back out normalised as (x-mean)/MAD in fixed point, offset-binary, one per handshake.
- Output feeds the DTW core's Input_squiggle load.
- Reciprocal of MAD is computed once per read by a sequential divider; each sample then costs one multiply.

Parameters:
- width, 16, raw input and normalised output sample width
- SQG_SIZE, 256, samples per read; power of two
- LOG2_SQG, 8, log2(SQG_SIZE)
- RECIP_FRAC, 24, fractional bits of reciprocal; reciprocal width RECIP_FRAC+1
- OUT_FRAC, 8, fractional bits of normalised output

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  raw sample valid
- in_ready  out  1  block accepts raw sample
- in_data  in  width  raw unsigned sample
- out_valid  out  1  normalised sample valid
- out_ready  in  1  downstream accepts
- out_data  out  width  normalised sample, offset-binary (0x8000 = mean)
- out_last  out  1  marks SQG_SIZE-th output of a read
- busy  out  1  high in any state except LOAD
- mad_zero  out  1  MAD of current read is 0; valid from DIV until next LOAD
- mean_o  out  width  latched mean (debug)
- mad_o  out  width  latched MAD (debug)

Behaviour:
- Reset: all outputs 0 except in_ready=1. State LOAD; address and accumulators 0. Reset mid-read discards partial data.
- Handshake: a transfer occurs when valid&ready on a rising edge. out_data, out_last, out_valid are held stable while out_valid&!out_ready.
- LOAD: in_ready=1. Each accepted sample is written to buffer[addr], addr++, and sum += in_data (width+LOG2_SQG bits, unsigned). On the SQG_SIZE-th accept, go to MEAN.
- MEAN (1 cycle): mean = sum >> LOG2_SQG (truncate). Latch mean_o.
- MAD (SQG_SIZE+1 cycles, synchronous buffer read): dsum += |x-mean|, where the difference is width+1 bits signed. At end, mad = dsum >> LOG2_SQG. Latch mad_o.
- DIV (RECIP_FRAC+1 cycles): recip = floor(2^RECIP_FRAC / mad), restoring divider, one quotient bit per cycle. If mad==0: skip the divider, recip=0, mad_zero=1 (still take the same cycle count).
- STREAM: for buffer samples in order, compute p = (x-mean)*recip as signed, arithmetic >> (RECIP_FRAC-OUT_FRAC).
  - Saturate to [-2^(width-1), 2^(width-1)-1].
  - out_data = sat XOR 2^(width-1).
  - 2-stage pipeline (read, compute/register) that stalls on !out_ready.
  - out_last accompanies the final sample. After its handshake, go to LOAD next cycle.
- Latency: first out_valid 285 cycles after the last input handshake (1+257+25+2) at defaults. Sustained 1 sample/cycle when out_ready=1.
- in_ready=0 outside LOAD; in_valid there is ignored.
- No overflow is possible in sum or dsum at defaults (max 2^24-1 each).

Decomposition:
- Package dtw_norm_pkg holds:
  - state enum {LOAD, MEAN, MAD, DIV, STREAM}
  - derived widths: SUM_W = width+LOG2_SQG, RECIP_W = RECIP_FRAC+1, PROD_W = width+1+RECIP_W
  - the offset constant
- Sub-module recip_divider: start/done, dividend fixed 2^RECIP_FRAC, width-bit divisor, RECIP_W quotient, iterative restoring.
- Buffer: single inferred sync-read RAM inside the top.

Test Plan:
- 256 samples all 1000 -> mean_o=1000, mad_o=0, mad_zero=1; 256 outputs of 0x8000; out_last on the 256th.
- Alternating 900/1100 -> mean 1000, MAD 100, recip 167772; outputs alternate 0x7F00/0x80FF.
- 255 samples of 0, last sample 65535 -> mean 255, MAD 509, recip 32961; outputs 0x7F7F x255, then 0xFFFF (saturated).
- Alternating-pattern read with out_ready toggled randomly -> identical output sequence, out_data stable during stalls; first out_valid exactly 285 cycles after last input (out_ready=1 run).
- Assert rst after 100 inputs, then a full all-1000 read -> first read discarded; exactly 256 outputs of 0x8000, in_ready low from the 256th accept until out_last handshake.
- Two back-to-back reads (pattern, then constant) -> second read's in_ready rises the cycle after the first read's out_last handshake; results are independent.
